// File: rtl/pulse_flasher.sv
// pulse_flasher: turns single-cycle event pulses into visible LED flashes.
// Each event gives ON_CYCLES of led_out high followed by OFF_CYCLES of dark gap.
// Events that arrive during a flash are queued in a saturating pending counter.
// When the counter is full, further events are dropped and the sticky overflow flag is set.
// Optional feature macro PULSE_SYNC_EN: pulse_in is then a raw asynchronous
// level. It passes through a two-flop synchronizer, and each rising edge is one event.
module pulse_flasher #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD    = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD   = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [PEND_W-1:0]  PEND_ONE   = PEND_W'(1);
  localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [PEND_W-1:0]    pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;

  logic                 ev;
  logic                 timer_done;
  logic                 start;

`ifdef PULSE_SYNC_EN
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Shift the raw level through the synchronizer and edge-detect delay stage
  always_comb begin
    s1_d = pulse_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer flops; cleared by reset so no stale edge appears after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign ev = s2_q & ~s3_q;
`else
  assign ev = pulse_in;
`endif

  assign timer_done = (timer_q == '0);

  // A flash may begin from IDLE or on the final gap cycle, provided there is work to do
  assign start = ((state_q == ST_IDLE) || ((state_q == ST_GAP) && timer_done)) &&
                 ((pending_q != '0) || ev);

  // Sequence the flash phases and count down the phase timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
        end
      end
      ST_ON: begin
        if (timer_done) begin
          state_d = ST_GAP;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          if (start) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Maintain the queue of waiting events: one update covers both the arrival and the consumption of an event
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (ev && !start) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (!ev && start) begin
      pending_d = pending_q - PEND_ONE;
    end
  end

  // Derive the registered outputs from the next state so they line up with the state register
  always_comb begin
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any flash immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_flasher.sv
// Testbench for pulse_flasher. It uses ON_CYCLES=3, OFF_CYCLES=2 and PEND_W=2.
// The stimulus side pushes hand-computed per-cycle expectations into a queue.
// A monitor then checks them on the falling clock edge.
module tb_pulse_flasher;

  localparam int ON_CYCLES  = 3;
  localparam int OFF_CYCLES = 2;
  localparam int PEND_W     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              pulse_in;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  typedef struct {
    string             tag;
    int                cyc;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              ovf;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   compared   = 0;
  int   mismatched = 0;

  pulse_flasher #(
    .ON_CYCLES (ON_CYCLES),
    .OFF_CYCLES(OFF_CYCLES),
    .PEND_W    (PEND_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Compare the live DUT outputs against one expectation record
  task automatic checkOutput(input exp_t e);
    compared++;
    if (led_out !== e.led || busy !== e.busy || pending !== e.pend || overflow !== e.ovf) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got led=%0b busy=%0b pending=%0d overflow=%0b, expected led=%0b busy=%0b pending=%0d overflow=%0b",
               e.tag, e.cyc, led_out, busy, pending, overflow, e.led, e.busy, e.pend, e.ovf);
    end
  endtask

  // Each character of the strings describes one cycle: pulse_in, then the expected led, busy, pending and overflow for that cycle
  task automatic applyStimulus(input string tag, input string p, input string l,
                               input string b, input string n, input string o);
    for (int i = 0; i < p.len(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      pulse_in = (p[i] == "1");
      e.tag  = tag;
      e.cyc  = i;
      e.led  = (l[i] == "1");
      e.busy = (b[i] == "1");
      e.pend = PEND_W'(int'(n[i]) - 48);
      e.ovf  = (o[i] == "1");
      expQ.push_back(e);
    end
  endtask

  // Hold reset for two cycles and expect all outputs to be cleared
  task automatic resetDut(input string tag);
    exp_t e;
    e.tag = tag; e.led = 1'b0; e.busy = 1'b0; e.pend = '0; e.ovf = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    pulse_in = 1'b0;
    e.cyc = 0;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e.cyc = 1;
    expQ.push_back(e);
    reset = 1'b0;
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  // Monitor: compare one queued expectation per falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        checkOutput(monE);
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached before the stimulus completed");
    printSummary();
    $finish;
  end

  // Directed test sequence
  initial begin
    exp_t asyncE;
    reset    = 1'b1;
    pulse_in = 1'b0;

`ifdef PULSE_SYNC_EN
    resetDut("t6_reset");
    applyStimulus("t6_sync_edges",
                  "1111111111001100000000",
                  "0001110000000001110000",
                  "0001111100000001111100",
                  "0000000000000000000000",
                  "0000000000000000000000");
`else
    resetDut("t1_reset");
    applyStimulus("t1_single",
                  "10000000",
                  "01110000",
                  "01111100",
                  "00000000",
                  "00000000");

    resetDut("t2_reset");
    applyStimulus("t2_queue3",
                  "111000000000000000",
                  "011100111001110000",
                  "011111111111111100",
                  "001222111110000000",
                  "000000000000000000");

    resetDut("t3_reset");
    applyStimulus("t3_saturate",
                  "11111000000000000000000",
                  "01110011100111001110000",
                  "01111111111111111111100",
                  "00123322222111110000000",
                  "00000111111111111111111");

    resetDut("t4_reset");
    applyStimulus("t4_lastgap",
                  "110001000000000000",
                  "011100111001110000",
                  "011111111111111100",
                  "001111111110000000",
                  "000000000000000000");

    resetDut("t5_reset");
    applyStimulus("t5_fill",
                  "1110",
                  "0111",
                  "0111",
                  "0012",
                  "0000");
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    asyncE.tag = "t5_async_reset"; asyncE.cyc = 0;
    asyncE.led = 1'b0; asyncE.busy = 1'b0; asyncE.pend = '0; asyncE.ovf = 1'b0;
    checkOutput(asyncE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus("t5_after",
                  "00000000",
                  "00000000",
                  "00000000",
                  "00000000",
                  "00000000");
`endif

    @(negedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL queue_drain: got %0d unchecked entries, expected 0", expQ.size());
    end
    printSummary();
    $finish;
  end

endmodule
